alu_mul_seq: RTL

Multi-cycle sequencer that borrows the shared 32-bit ALU to perform unsigned 32×32→64 shift-add multiplication (MULTU) into HI/LO. Outside a multiply it is a transparent pass-through, so the pipeline's own ALU operands and control reach the ALU unchanged. While a multiply runs it owns the ALU and holds `busy` high so the pipeline stalls. It sits between the execute-stage operand/control muxes and the ALU instance.

---
 rtl/alu_mul_seq_if.sv | 37 +++
 rtl/alu_mul_seq.sv | 101 ++++++++++
 2 files changed

// File: rtl/alu_mul_seq_if.sv
// Bus bundle between the execute stage, the multiply sequencer and the shared
// ALU. The master side is the pipeline plus the ALU instance; the slave side
// is the sequencer that sits between them.
interface alu_mul_seq_if #(
  parameter int WIDTH = 32
);
  // Multiply request / result
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline ALU operands and control
  logic [WIDTH-1:0] cpu_a;
  logic [WIDTH-1:0] cpu_b;
  logic [4:0]       cpu_ctr;

  // Drive into and result from the shared ALU
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [4:0]       alu_ctr;
  logic [WIDTH-1:0] alu_y;
  logic             alu_ovflow;

  modport master (
    output start, op_a, op_b, cpu_a, cpu_b, cpu_ctr, alu_y, alu_ovflow,
    input  busy, done, hi, lo, alu_a, alu_b, alu_ctr
  );

  modport slave (
    input  start, op_a, op_b, cpu_a, cpu_b, cpu_ctr, alu_y, alu_ovflow,
    output busy, done, hi, lo, alu_a, alu_b, alu_ctr
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier that borrows the
// shared ALU for one add per step. Outside a multiply the ALU inputs are a
// straight mux from the pipeline operands; during RUN the sequencer owns the
// ALU and holds busy so the pipeline stalls.
module alu_mul_seq #(
  parameter int         WIDTH   = 32,
  parameter logic [4:0] CTR_ADD = 5'b00000
) (
  input logic          clk,
  input logic          rst,
  alu_mul_seq_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CW-1:0]    count;
  logic             busy_q;
  logic             done_q;

  // Sequencer FSM: captures operands, runs WIDTH shift-add steps, pulses done.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; a blocking = would let later lines see already-updated
  // hi/lo within the same step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      count  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= bus.op_a;
            hi_q   <= '0;
            lo_q   <= bus.op_b;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          // The ALU sum is WIDTH+1 bits wide (carry in alu_ovflow); the
          // whole {carry, sum, lo} register shifts right by one each step.
          hi_q  <= {bus.alu_ovflow, bus.alu_y[WIDTH-1:1]};
          lo_q  <= {bus.alu_y[0], lo_q[WIDTH-1:1]};
          count <= count + 1'b1;
          if (count == LAST) begin
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // ALU drive: pass-through except during RUN, where the partial product
  // high word plus (multiplier LSB ? multiplicand : 0) is added.
  // NOTE: every output gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    bus.alu_a   = bus.cpu_a;
    bus.alu_b   = bus.cpu_b;
    bus.alu_ctr = bus.cpu_ctr;
    if (state == RUN) begin
      bus.alu_a   = hi_q;
      bus.alu_b   = lo_q[0] ? mcand : '0;
      bus.alu_ctr = CTR_ADD;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
